// File: rtl/cpu_pkg.sv
// Shared CPU types: register address, register-file write port bundle,
// and the buffered M-unit result entry.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic            we;
        reg_addr_t       waddr;
        logic [XLEN-1:0] wd;
    } rf_wr_t;

    typedef struct packed {
        reg_addr_t       waddr;
        logic [XLEN-1:0] wd;
    } md_entry_t;

endpackage

// File: rtl/md_result_fifo.sv
// Synchronous FIFO holding M-unit results that lost arbitration to the
// pipeline writeback path. Head entry is visible combinationally.
module md_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of its neighbours.
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; count/pointers make stale slots unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Sole driver of the register-file write port: pipeline writeback first,
// then buffered M results, then a direct M bypass; plus the busy scoreboard.
module reg_write_arbiter #(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREG  = 32,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_we,
    input  cpu_pkg::reg_addr_t wb_waddr,
    input  logic [XLEN-1:0]    wb_wd,
    input  logic               md_issue,
    input  cpu_pkg::reg_addr_t md_issue_rd,
    input  logic               md_valid,
    input  cpu_pkg::reg_addr_t md_waddr,
    input  logic [XLEN-1:0]    md_wd,
    output logic               md_ready,
    output logic               rf_we,
    output cpu_pkg::reg_addr_t rf_waddr,
    output logic [XLEN-1:0]    rf_wd,
    output logic [NREG-1:0]    busy
);

    import cpu_pkg::*;

    md_entry_t             fifo_head;
    md_entry_t             fifo_in;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_count_unused;
    logic                  fifo_push;
    logic                  fifo_pop;

    rf_wr_t                wr;
    logic                  wb_act;
    logic                  md_acc;
    logic                  clr_en;
    reg_addr_t             clr_addr;
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_d;

    assign wb_act  = wb_we && (wb_waddr != '0);
    // Readiness looks only at registered fullness; a same-cycle pop does not help.
    assign md_ready = rst && !fifo_full;
    assign md_acc   = md_valid && md_ready;
    assign fifo_in  = '{waddr: md_waddr, wd: md_wd};
    assign fifo_count_unused = ^fifo_count;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        wr        = '0;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        clr_en    = 1'b0;
        clr_addr  = '0;
        if (rst) begin
            if (wb_act) begin
                wr = '{we: 1'b1, waddr: wb_waddr, wd: wb_wd};
            end else if (!fifo_empty) begin
                wr       = '{we: 1'b1, waddr: fifo_head.waddr, wd: fifo_head.wd};
                fifo_pop = 1'b1;
                clr_en   = 1'b1;
                clr_addr = fifo_head.waddr;
            end else if (md_acc && md_waddr != '0) begin
                wr       = '{we: 1'b1, waddr: md_waddr, wd: md_wd};
                clr_en   = 1'b1;
                clr_addr = md_waddr;
            end
            // Enqueue whenever the accepted result was not the one bypassed.
            fifo_push = md_acc && (md_waddr != '0) && (wb_act || !fifo_empty);
        end
    end

    assign rf_we    = wr.we;
    assign rf_waddr = wr.waddr;
    assign rf_wd    = wr.wd;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        // A new issue to the same register is still outstanding, so set wins.
        if (md_issue && md_issue_rd != '0) busy_d[md_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy = busy_q;

    md_result_fifo #(
        .WIDTH ($bits(md_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule
